// File: rtl/exp5_pkg.sv
// Shared state codes, output bundle and output decode for the game control unit.
package exp5_pkg;

  localparam int unsigned EstadoW = 4;

  typedef enum logic [EstadoW-1:0] {
    StInicial    = 4'b0000,
    StPreparacao = 4'b0001,
    StEspera     = 4'b0010,
    StRegistra   = 4'b0100,
    StComparacao = 4'b0101,
    StProximo    = 4'b0110,
    StFimAcertou = 4'b1010,
    StFimErrou   = 4'b1110,
    StFimTimeout = 4'b1101
  } estado_t;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore output decode: a pure function of the state code.
  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      StPreparacao: begin
        s.zera_c = 1'b1;
        s.zera_r = 1'b1;
      end
      StRegistra:   s.registra_r = 1'b1;
      StProximo:    s.conta_c = 1'b1;
      StFimAcertou: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      StFimErrou: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      StFimTimeout: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: pulso is high when sinal is 1 now and was 0 at the previous clock edge.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;

  // One-cycle history of the input level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal;
    end
  end

  assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/exp5_unidade_controle.sv
// Control unit for the memory game round (Moore FSM).
// Optional ESPERA timeout is built only when macro TIMEOUT_EN is defined.
module exp5_unidade_controle
  import exp5_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               jogada,
  input  logic               chavesIgualMemoria,
  input  logic               fimC,
  output logic               zeraC,
  output logic               contaC,
  output logic               zeraR,
  output logic               registraR,
  output logic               pronto,
  output logic               acertou,
  output logic               errou,
  output logic               timeout,
  output logic [EstadoW-1:0] db_estado
);

  estado_t estado_q, estado_d;
  saidas_t saidas_q;
  logic    jogada_pulso;

  edge_detector u_edge_detector (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jogada_pulso)
  );

`ifdef TIMEOUT_EN
  logic [31:0] espera_cnt_q;
  logic        espera_expirou;

  assign espera_expirou = (espera_cnt_q == TIMEOUT_CICLOS - 32'd1);

  // Cycles spent in ESPERA; restarts on every entry into ESPERA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      espera_cnt_q <= '0;
    end else if (estado_q != StEspera && estado_d == StEspera) begin
      espera_cnt_q <= '0;
    end else if (estado_q == StEspera) begin
      espera_cnt_q <= espera_cnt_q + 32'd1;
    end
  end
`endif

  // Next-state logic; iniciar only matters in INICIAL and the FIM states.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial:    if (iniciar) estado_d = StPreparacao;
      StPreparacao: estado_d = StEspera;
      StEspera: begin
        if (jogada_pulso) begin
          estado_d = StRegistra;
        end
`ifdef TIMEOUT_EN
        // A move arriving in the final cycle wins over the timeout.
        else if (espera_expirou) begin
          estado_d = StFimTimeout;
        end
`endif
      end
      StRegistra:   estado_d = StComparacao;
      StComparacao: begin
        if (!chavesIgualMemoria) begin
          estado_d = StFimErrou;
        end else if (fimC) begin
          estado_d = StFimAcertou;
        end else begin
          estado_d = StProximo;
        end
      end
      StProximo:    estado_d = StEspera;
      StFimAcertou: if (iniciar) estado_d = StPreparacao;
      StFimErrou:   if (iniciar) estado_d = StPreparacao;
`ifdef TIMEOUT_EN
      StFimTimeout: if (iniciar) estado_d = StPreparacao;
`endif
      default:      estado_d = StInicial;
    endcase
  end

  // State and outputs registered together so outputs track the state code exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= decodifica(estado_d);
    end
  end

  assign zeraC     = saidas_q.zera_c;
  assign contaC    = saidas_q.conta_c;
  assign zeraR     = saidas_q.zera_r;
  assign registraR = saidas_q.registra_r;
  assign pronto    = saidas_q.pronto;
  assign acertou   = saidas_q.acertou;
  assign errou     = saidas_q.errou;
  assign db_estado = estado_q;

`ifdef TIMEOUT_EN
  assign timeout = saidas_q.timeout;
`else
  assign timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = saidas_q.timeout ^ (^TIMEOUT_CICLOS);
`endif

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Self-checking bench for exp5_unidade_controle: vector table, corner sequences, random vs model.
module tb_exp5_unidade_controle;

  localparam int unsigned T = 8;
`ifdef TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimc;
  logic zerac, contac, zerar, registrar, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  exp5_unidade_controle #(
    .TIMEOUT_CICLOS (T)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .iniciar            (iniciar),
    .jogada             (jogada),
    .chavesIgualMemoria (igual),
    .fimC               (fimc),
    .zeraC              (zerac),
    .contaC             (contac),
    .zeraR              (zerar),
    .registraR          (registrar),
    .pronto             (pronto),
    .acertou            (acertou),
    .errou              (errou),
    .timeout            (timeout),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  // {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  logic [11:0] act;
  assign act = {db_estado, zerac, contac, zerar, registrar, pronto, acertou, errou, timeout};

  // Expected observation for a state code, straight from the state/output table.
  function automatic logic [11:0] esperado(input logic [3:0] c);
    logic [7:0] o;
    o = 8'h00;
    if (c == 4'b0001) o = 8'b1010_0000;
    if (c == 4'b0100) o = 8'b0001_0000;
    if (c == 4'b0110) o = 8'b0100_0000;
    if (c == 4'b1010) o = 8'b0000_1100;
    if (c == 4'b1110) o = 8'b0000_1010;
    if (c == 4'b1101) o = 8'b0000_1001;
    return {c, o};
  endfunction

  task automatic check(input string nome, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got estado=%b outs=%b, expected estado=%b outs=%b",
               nome, got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  // Reference model: game rules in terms of state codes and a count of idle cycles.
  logic [3:0] m_state;
  logic       m_prev;
  int         m_wait;

  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic ini,
                                            input logic edge_, input logic ig, input logic fc,
                                            input int w);
    logic [3:0] n;
    n = cur;
    case (cur)
      4'b0000: n = ini ? 4'b0001 : 4'b0000;
      4'b0001: n = 4'b0010;
      4'b0010: begin
        if (edge_) n = 4'b0100;
        else if (TimeoutEn && w == int'(T) - 1) n = 4'b1101;
      end
      4'b0100: n = 4'b0101;
      4'b0101: n = !ig ? 4'b1110 : (fc ? 4'b1010 : 4'b0110);
      4'b0110: n = 4'b0010;
      4'b1010, 4'b1110, 4'b1101: n = ini ? 4'b0001 : cur;
      default: n = 4'b0000;
    endcase
    return n;
  endfunction

  typedef struct {
    logic        ini;
    logic        jog;
    logic        ig;
    logic        fc;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic i, input logic j, input logic g, input logic f,
                              input logic [3:0] c);
    vec_t v;
    v.ini = i; v.jog = j; v.ig = g; v.fc = f; v.exp = esperado(c);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] nxt;
    logic       edge_;

    // Start, held-key hit move, miss, restart, iniciar ignored mid-round.
    tbl[0]  = mk(1, 0, 0, 0, 4'b0001);
    tbl[1]  = mk(0, 0, 0, 0, 4'b0010);
    tbl[2]  = mk(0, 1, 1, 0, 4'b0100);
    tbl[3]  = mk(0, 1, 1, 0, 4'b0101);
    tbl[4]  = mk(0, 1, 1, 0, 4'b0110);
    tbl[5]  = mk(0, 1, 1, 0, 4'b0010);
    tbl[6]  = mk(0, 1, 1, 0, 4'b0010);
    tbl[7]  = mk(0, 0, 1, 0, 4'b0010);
    tbl[8]  = mk(0, 1, 0, 0, 4'b0100);
    tbl[9]  = mk(0, 1, 0, 0, 4'b0101);
    tbl[10] = mk(0, 0, 0, 0, 4'b1110);
    tbl[11] = mk(0, 0, 0, 0, 4'b1110);
    tbl[12] = mk(1, 0, 0, 0, 4'b0001);
    tbl[13] = mk(1, 0, 0, 0, 4'b0010);
    tbl[14] = mk(0, 0, 0, 0, 4'b0010);

    reset = 1'b0; iniciar = 0; jogada = 0; igual = 0; fimc = 0;
    tick();
    tick();
    check("reset_state", act, 12'h000);
    reset = 1'b1;
    tick();
    check("idle_after_release", act, 12'h000);

    for (int i = 0; i < 15; i++) begin
      iniciar = tbl[i].ini; jogada = tbl[i].jog; igual = tbl[i].ig; fimc = tbl[i].fc;
      tick();
      check($sformatf("vec%0d", i), act, tbl[i].exp);
    end

    // Async reset in ESPERA takes effect with no clock edge.
    reset = 1'b0;
    #1;
    check("reset_mid_espera", act, 12'h000);
    reset = 1'b1;
    iniciar = 1'b1;
    tick();
    check("start_prep", act, esperado(4'b0001));
    iniciar = 1'b0;
    tick();
    check("start_espera", act, esperado(4'b0010));

    // Full round of 16 matching moves.
    for (int i = 0; i < 16; i++) begin
      jogada = 1'b1; igual = 1'b1; fimc = (i == 15);
      tick();
      check($sformatf("round_reg%0d", i), act, esperado(4'b0100));
      jogada = 1'b0;
      tick();
      check($sformatf("round_cmp%0d", i), act, esperado(4'b0101));
      tick();
      if (i == 15) begin
        check("round_acertou", act, esperado(4'b1010));
      end else begin
        check($sformatf("round_prox%0d", i), act, esperado(4'b0110));
        tick();
        check($sformatf("round_esp%0d", i), act, esperado(4'b0010));
      end
    end
    tick();
    check("acertou_hold", act, esperado(4'b1010));

    // Reset held across an edge, then release takes effect at the next edge.
    reset = 1'b0;
    #1;
    check("reset_in_fim", act, 12'h000);
    iniciar = 1'b1;
    tick();
    check("reset_held_edge", act, 12'h000);
    reset = 1'b1;
    tick();
    check("release_first_edge", act, esperado(4'b0001));
    iniciar = 1'b0;
    tick();
    check("timeout_enter", act, esperado(4'b0010));

    // Idle in ESPERA: timeout on the 8th cycle when enabled, otherwise wait forever.
    jogada = 1'b0;
    for (int k = 1; k < int'(T); k++) begin
      tick();
      check($sformatf("wait%0d", k), act, esperado(4'b0010));
    end
    tick();
`ifdef TIMEOUT_EN
    check("timeout_fire", act, esperado(4'b1101));
    iniciar = 1'b1;
    tick();
    check("timeout_restart", act, esperado(4'b0001));
    iniciar = 1'b0;
    tick();
    for (int k = 1; k < int'(T); k++) begin
      tick();
      check($sformatf("wait2_%0d", k), act, esperado(4'b0010));
    end
    jogada = 1'b1;
    tick();
    check("move_beats_timeout", act, esperado(4'b0100));
    jogada = 1'b0;
`else
    check("no_timeout", act, esperado(4'b0010));
    for (int k = 0; k < 20; k++) tick();
    check("still_waiting", act, esperado(4'b0010));
`endif

    // Randomized run against the model, with occasional async resets.
    pulse_reset();
    m_state = 4'b0000; m_prev = 1'b0; m_wait = 0;
    jogada = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      iniciar = ($urandom_range(7) == 0);
      if ($urandom_range(2) == 0) jogada = ~jogada;
      igual   = ($urandom_range(7) != 0);
      fimc    = ($urandom_range(3) == 0);
      edge_   = jogada && !m_prev;
      nxt     = model_next(m_state, iniciar, edge_, igual, fimc, m_wait);
      if (nxt == 4'b0010 && m_state != 4'b0010) m_wait = 0;
      else if (m_state == 4'b0010) m_wait++;
      m_state = nxt;
      m_prev  = jogada;
      tick();
      check($sformatf("rand%0d", n), act, esperado(m_state));
      if ($urandom_range(63) == 0) begin
        reset = 1'b0;
        #1;
        check($sformatf("rand_reset%0d", n), act, 12'h000);
        reset = 1'b1;
        m_state = 4'b0000; m_prev = 1'b0; m_wait = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp5_unidade_controle.md
EXP5_UNIDADE_CONTROLE -- requirements
Module: exp5_unidade_controle

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CICLOS, default 5000, giving the number of cycles allowed in ESPERA before timeout (used only with TIMEOUT_EN).
REQ-002 The block SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port iniciar  in  1  level; starts a round from INICIAL or any FIM state.
REQ-005 The block SHALL have port jogada  in  1  level; high while any key is pressed.
REQ-006 The block SHALL have port chavesIgualMemoria  in  1  datapath comparator result.
REQ-007 The block SHALL have port fimC  in  1  datapath address counter at terminal count 15.
REQ-008 The block SHALL have ports zeraC, contaC, zeraR, registraR  out  1 each  datapath control strobes.
REQ-009 The block SHALL have ports pronto, acertou, errou, timeout  out  1 each  round status.
REQ-010 The block SHALL have port db_estado  out  4  current state code, for debug display.

Function
REQ-011 The FSM SHALL be Moore: every output decoded from the registered state only.
REQ-012 State codes SHALL be: INICIAL 0000, PREPARACAO 0001, ESPERA 0010, REGISTRA 0100, COMPARACAO 0101, PROXIMO 0110, FIM_ACERTOU 1010, FIM_ERROU 1110, FIM_TIMEOUT 1101.
REQ-013 INICIAL: all outputs 0; iniciar=1 -> PREPARACAO, else stay.
REQ-014 PREPARACAO: zeraC=1, zeraR=1 for exactly one cycle -> ESPERA unconditionally.
REQ-015 ESPERA: all strobes 0; on a jogada rising edge -> REGISTRA, else stay.
REQ-016 Jogada rising edge SHALL mean jogada=1 at the current clock edge and 0 at the previous edge; holding a key SHALL yield one move only.
REQ-017 REGISTRA: registraR=1 for one cycle -> COMPARACAO.
REQ-018 COMPARACAO: chavesIgualMemoria=0 -> FIM_ERROU; =1 with fimC=1 -> FIM_ACERTOU; =1 with fimC=0 -> PROXIMO.
REQ-019 PROXIMO: contaC=1 for one cycle -> ESPERA.
REQ-020 FIM_ACERTOU: pronto=1, acertou=1; FIM_ERROU: pronto=1, errou=1; FIM_TIMEOUT: pronto=1, timeout=1; in each, iniciar=1 -> PREPARACAO, else stay.
REQ-021 iniciar SHALL be ignored in PREPARACAO through PROXIMO.
REQ-022 A jogada edge in any state other than ESPERA SHALL be discarded, not queued.
REQ-023 Any unlisted state code SHALL transition to INICIAL on the next edge.
REQ-024 db_estado SHALL equal the state code in the same cycle.

Reset
REQ-025 reset=0 SHALL immediately force INICIAL, all outputs 0, the edge-detect history to 0 and the timeout counter to 0, regardless of clock, including mid-round.
REQ-026 Release of reset SHALL take effect at the first rising clock edge after reset=1.

Configuration
REQ-027 With macro TIMEOUT_EN defined, a counter SHALL clear on entry to ESPERA, increment each cycle in ESPERA, and force FIM_TIMEOUT when it reaches TIMEOUT_CICLOS-1 without a jogada edge; a jogada edge in that same cycle SHALL take priority (-> REGISTRA).
REQ-028 Without TIMEOUT_EN, the counter and FIM_TIMEOUT SHALL not be built; timeout SHALL be tied 0 and ESPERA waits indefinitely.

Structure
REQ-029 State codes and their width SHALL live in shared package exp5_pkg.
REQ-030 Jogada edge detection SHALL be a sub-module edge_detector (clock, reset, sinal, pulso).

Verification
REQ-031 Reset: reset=0 mid-ESPERA -> db_estado=0000, all outputs 0 without a clock edge.
REQ-032 Start: iniciar pulse in INICIAL -> next cycle zeraC=zeraR=1 (0001), then 0010.
REQ-033 Hit move: jogada held 5 cycles, chavesIgualMemoria=1, fimC=0 -> states 0100, 0101, 0110, 0010; registraR and contaC each high exactly one cycle; no second move.
REQ-034 Full round: 16 moves all matching, fimC=1 on 16th -> 1010, pronto=acertou=1.
REQ-035 Miss: chavesIgualMemoria=0 in COMPARACAO -> 1110, errou=1; iniciar=1 -> 0001.
REQ-036 With TIMEOUT_EN, TIMEOUT_CICLOS=8: no jogada for 8 cycles in ESPERA -> 1101, timeout=1; jogada edge on 8th cycle -> 0100 instead.
